// File: rtl/uart_frame_parser_pkg.sv
// Shared types for the UART frame parser: byte/word aliases, parser state
// encoding, the default sync marker and a buffer pointer-width helper.
package uart_frame_parser_pkg;

  typedef logic [7:0]  u8;
  typedef logic [15:0] u16;
  typedef logic [31:0] u32;

  // Parser state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_HUNT    = 3'd0;
  localparam state_t ST_CMD     = 3'd1;
  localparam state_t ST_LEN     = 3'd2;
  localparam state_t ST_PAYLOAD = 3'd3;
  localparam state_t ST_CSUM    = 3'd4;
  localparam state_t ST_DELIVER = 3'd5;

  localparam u8 DEFAULT_SYNC_BYTE = 8'hA5;

  // Address width for a buffer of the given depth (at least one bit)
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_parser_frame_buffer.sv
// Payload store for one frame: DEPTH x 8 registers, synchronous write,
// asynchronous read.
// Ports: clk, we/wr_addr/wr_data (write side), rd_addr/rd_data_c (read side).
module uart_frame_parser_frame_buffer
  import uart_frame_parser_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  u8             wr_data,
  input  logic [AW-1:0] rd_addr,
  output u8             rd_data_c
);

  u8 mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Combinational read port
  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Framed command parser on the read side of the UART receive FIFO.
// Hunts for SYNC_BYTE, parses cmd/len/payload/XOR checksum, buffers the
// payload and releases it as a valid/ready byte stream once the checksum
// matches. Bad length, bad checksum and inter-byte stalls drop the frame and
// raise a one-cycle error pulse.
// Ports: clk, rst_n; in_empty/in_rd_en/in_data (FIFO read side);
//        out_valid/out_ready/out_data/out_last/out_cmd/out_len (payload stream);
//        csum_err/len_err/timeout_err (error pulses).
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 32,
  parameter u8           SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_empty,
  output logic       in_rd_en,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] out_cmd,
  output logic [7:0] out_len,
  output logic       csum_err,
  output logic       len_err,
  output logic       timeout_err
);

  localparam int unsigned AW = ptr_width(MAX_LEN);

  state_t state_q, state_d;
  u8      csum_q, csum_d;
  u8      wr_ptr_q, wr_ptr_d;
  u8      rd_ptr_q, rd_ptr_d;
  u32     tmo_cnt_q, tmo_cnt_d;
  logic   cap_q;
  logic   rd_en_d, valid_d, last_d;
  u8      data_d, cmd_d, len_d;
  logic   csum_err_d, len_err_d, timeout_err_d;
  logic   buf_we;
  logic   in_frame;
  logic [AW-1:0] rd_addr_c;
  u8      buf_rd_data_c;

  // Next beat address: first beat on entry to DELIVER, else the following one
  assign rd_addr_c = (state_q == ST_DELIVER) ? AW'(rd_ptr_q + 8'd1) : '0;

  assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

  uart_frame_parser_frame_buffer #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk       (clk),
    .we        (buf_we),
    .wr_addr   (AW'(wr_ptr_q)),
    .wr_data   (in_data),
    .rd_addr   (rd_addr_c),
    .rd_data_c (buf_rd_data_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      csum_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
      cap_q       <= 1'b0;
      in_rd_en    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_cmd     <= '0;
      out_len     <= '0;
      csum_err    <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      csum_q      <= csum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cap_q       <= in_rd_en;
      in_rd_en    <= rd_en_d;
      out_valid   <= valid_d;
      out_data    <= data_d;
      out_last    <= last_d;
      out_cmd     <= cmd_d;
      out_len     <= len_d;
      csum_err    <= csum_err_d;
      len_err     <= len_err_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Next-state and output logic; cap_q marks in_data as a freshly read byte
  always_comb begin
    state_d       = state_q;
    csum_d        = csum_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tmo_cnt_d     = '0;
    cmd_d         = out_cmd;
    len_d         = out_len;
    valid_d       = out_valid;
    data_d        = out_data;
    last_d        = out_last;
    csum_err_d    = 1'b0;
    len_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    buf_we        = 1'b0;

    if (in_frame) tmo_cnt_d = cap_q ? '0 : tmo_cnt_q + 32'd1;

    case (state_q)
      ST_HUNT: begin
        if (cap_q && (in_data == SYNC_BYTE)) begin
          state_d = ST_CMD;
          csum_d  = '0;
        end
      end
      ST_CMD: begin
        if (cap_q) begin
          cmd_d   = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (cap_q) begin
          csum_d = csum_q ^ in_data;
          len_d  = in_data;
          if (32'(in_data) > MAX_LEN) begin
            len_err_d = 1'b1;
            state_d   = ST_HUNT;
          end else if (in_data == 8'd0) begin
            state_d = ST_CSUM;
          end else begin
            wr_ptr_d = '0;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (cap_q) begin
          buf_we   = 1'b1;
          csum_d   = csum_q ^ in_data;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q == out_len - 8'd1) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (cap_q) begin
          if (in_data == csum_q) begin
            state_d  = ST_DELIVER;
            rd_ptr_d = '0;
            valid_d  = 1'b1;
            // Empty frames present a single zero beat
            data_d   = (out_len == 8'd0) ? 8'd0 : buf_rd_data_c;
            last_d   = (out_len <= 8'd1);
          end else begin
            csum_err_d = 1'b1;
            state_d    = ST_HUNT;
          end
        end
      end
      ST_DELIVER: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            state_d = ST_HUNT;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            rd_ptr_d = rd_ptr_q + 8'd1;
            data_d   = buf_rd_data_c;
            last_d   = (rd_ptr_q + 8'd1 == out_len - 8'd1);
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Inter-byte stall abort; only fires without a capture, so never
    // coincides with a length or checksum error
    if (in_frame && !cap_q && (tmo_cnt_q + 32'd1 == TIMEOUT)) begin
      timeout_err_d = 1'b1;
      tmo_cnt_d     = '0;
      state_d       = ST_HUNT;
    end

    // One read in flight at most; the FIFO buffers input during delivery
    rd_en_d = !in_empty && !in_rd_en && (state_d != ST_DELIVER);
  end

endmodule
